// File: rtl/runway_wind_decoder.sv
// runway_wind_decoder: recovers confirmed wind direction from the runway lamp pattern sequence.
// Define WIND_ERR_COUNT_EN to add the saturating err_count output (width ERR_W).
module runway_wind_decoder #(
    parameter int CONFIRM_CYCLES = 2
`ifdef WIND_ERR_COUNT_EN
    , parameter int ERR_W = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       lights,
    output logic [1:0]       wind,
    output logic             wind_valid,
    output logic             err,
    output logic             locked
`ifdef WIND_ERR_COUNT_EN
    , output logic [ERR_W-1:0] err_count
`endif
);
    typedef enum logic {ACQUIRE, TRACK} state_t;
    localparam logic [2:0] CC = 3'(CONFIRM_CYCLES);
    state_t state;
    logic [2:0] l1, l2, prev, cnt, nxt_cnt, dec;
    logic [1:0] cand;
    logic legal_l2, bad;
    // Returns {legal_pair, wind} for a prev -> cur lamp transition.
    function automatic logic [2:0] decode(input logic [2:0] p, input logic [2:0] c);
        case ({p, c})
            6'b101_010, 6'b010_101, 6'b001_101, 6'b100_101: decode = 3'b100;
            6'b101_001, 6'b010_100, 6'b001_010, 6'b100_001: decode = 3'b101;
            6'b101_100, 6'b010_001, 6'b001_100, 6'b100_010: decode = 3'b110;
            default:                                        decode = 3'b000;
        endcase
    endfunction
    always_comb begin
        legal_l2 = (l2 == 3'b101) || (l2 == 3'b010) || (l2 == 3'b001) || (l2 == 3'b100);
        dec = decode(prev, l2);
        nxt_cnt = (dec[1:0] == cand) ? ((cnt >= CC) ? CC : cnt + 3'd1) : 3'd1;
        bad = (state == TRACK) && !(legal_l2 && dec[2]);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACQUIRE;
            l1 <= '0;
            l2 <= '0;
            prev <= '0;
            cand <= '0;
            cnt <= '0;
            wind <= '0;
            wind_valid <= 1'b0;
            err <= 1'b0;
            locked <= 1'b0;
        end else begin
            l1 <= lights;
            l2 <= l1;
            err <= bad;
            case (state)
                ACQUIRE: if (legal_l2) begin
                    prev <= l2;
                    state <= TRACK;
                    locked <= 1'b1;
                end
                TRACK: if (!legal_l2) begin
                    wind_valid <= 1'b0;
                    cnt <= '0;
                    state <= ACQUIRE;
                    locked <= 1'b0;
                end else if (dec[2]) begin
                    prev <= l2;
                    cand <= dec[1:0];
                    cnt <= nxt_cnt;
                    if (nxt_cnt == CC) begin
                        wind <= dec[1:0];
                        wind_valid <= 1'b1;
                    end
                end else begin
                    wind_valid <= 1'b0;
                    cnt <= '0;
                    prev <= l2;
                end
                default: state <= ACQUIRE;
            endcase
        end
    end
`ifdef WIND_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) err_count <= '0;
        else if (bad && err_count != '1) err_count <= err_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_runway_wind_decoder.sv
// tb_runway_wind_decoder: table-driven scoreboard bench for runway_wind_decoder (two-edge decode latency).
// With WIND_ERR_COUNT_EN defined, also checks err_count saturation at ERR_W=2.
module tb_runway_wind_decoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] lights = 3'b000;
    logic [1:0] wind;
    logic wind_valid, err, locked;
`ifdef WIND_ERR_COUNT_EN
    logic [1:0] err_count;
`endif
    int total = 0;
    int bad = 0;

    runway_wind_decoder #(
        .CONFIRM_CYCLES(2)
`ifdef WIND_ERR_COUNT_EN
        , .ERR_W(2)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .lights(lights),
        .wind(wind),
        .wind_valid(wind_valid),
        .err(err),
        .locked(locked)
`ifdef WIND_ERR_COUNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] lights;
        logic [1:0] wind;
        logic       valid;
        logic       err;
        logic       locked;
    } vec_t;

    vec_t vecs [27];
    vec_t q [$];
    vec_t e;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input int idx);
        e = q.pop_front();
        chk($sformatf("vec%0d {wind,valid,err,locked}", idx),
            {27'd0, wind, wind_valid, err, locked}, {27'd0, e.wind, e.valid, e.err, e.locked});
    endtask

    initial begin
        // lights, expected wind, wind_valid, err, locked two edges later
        vecs[0]  = '{3'b101, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{3'b010, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{3'b101, 2'b00, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{3'b010, 2'b00, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{3'b101, 2'b00, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{3'b001, 2'b00, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{3'b010, 2'b01, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{3'b100, 2'b01, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{3'b001, 2'b01, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{3'b100, 2'b01, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{3'b010, 2'b10, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{3'b010, 2'b10, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{3'b001, 2'b10, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{3'b100, 2'b10, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{3'b111, 2'b10, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{3'b111, 2'b10, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{3'b101, 2'b10, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{3'b010, 2'b10, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{3'b101, 2'b00, 1'b1, 1'b0, 1'b1};
        vecs[19] = '{3'b011, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[20] = '{3'b100, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[21] = '{3'b100, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[22] = '{3'b101, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[23] = '{3'b001, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[24] = '{3'b100, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[25] = '{3'b010, 2'b10, 1'b1, 1'b0, 1'b1};
        vecs[26] = '{3'b000, 2'b10, 1'b0, 1'b1, 1'b0};

        tick;
        tick;
        chk("reset wind", {30'd0, wind}, 32'd0);
        chk("reset wind_valid", {31'd0, wind_valid}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        chk("reset locked", {31'd0, locked}, 32'd0);
`ifdef WIND_ERR_COUNT_EN
        chk("reset err_count", {30'd0, err_count}, 32'd0);
`endif
        reset = 1'b0;

        for (int i = 0; i < 27; i++) begin
            lights = vecs[i].lights;
            q.push_back(vecs[i]);
            tick;
            if (q.size() > 2) pop_chk(i - 2);
        end
        for (int i = 25; i < 27; i++) begin
            tick;
            pop_chk(i);
        end

        // Lock with a left-to-right run, then reset mid-sequence.
        lights = 3'b101; tick;
        lights = 3'b100; tick;
        lights = 3'b010; tick;
        tick;
        tick;
        chk("ltr wind", {30'd0, wind}, 32'd2);
        chk("ltr wind_valid", {31'd0, wind_valid}, 32'd1);
        chk("ltr locked", {31'd0, locked}, 32'd1);
        reset = 1'b1;
        tick;
        chk("midreset wind", {30'd0, wind}, 32'd0);
        chk("midreset wind_valid", {31'd0, wind_valid}, 32'd0);
        chk("midreset locked", {31'd0, locked}, 32'd0);
        chk("midreset err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        tick;
        tick;
        chk("sync flops cleared, not locked yet", {31'd0, locked}, 32'd0);
        tick;
        chk("relock after reset", {31'd0, locked}, 32'd1);

`ifdef WIND_ERR_COUNT_EN
        // Held 010 repeats the same code: one illegal pair per cycle.
        repeat (5) tick;
        chk("err_count saturates", {30'd0, err_count}, 32'd3);
        chk("repeat keeps lock", {31'd0, locked}, 32'd1);
        reset = 1'b1;
        tick;
        chk("err_count cleared", {30'd0, err_count}, 32'd0);
        chk("err_count reset locked", {31'd0, locked}, 32'd0);
        reset = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
